// File: rtl/mac_pkg.sv
// Shared parameters, state encoding and sign-extension helper for the
// 16-lane signed 8-bit MAC feeder.
package mac_pkg;

  localparam int unsigned bw      = 8;             // element width
  localparam int unsigned pr      = 16;            // lanes per MAC group
  localparam int unsigned bw_psum = 2 * bw + 6;    // MAC sum width
  localparam int unsigned acc_bw  = 32;            // accumulator width
  localparam int unsigned cnt_w   = $clog2(pr);    // lane counter width

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    WAIT  = 2'd1,
    ACCUM = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Sign-extend a MAC sum to accumulator width.
  function automatic logic signed [acc_bw-1:0] sext(input logic signed [bw_psum-1:0] x);
    return {{(acc_bw - bw_psum){x[bw_psum-1]}}, x};
  endfunction

endpackage

// File: rtl/mac_16in_feeder_if.sv
// Bus bundle between the feeder, its element source, the MAC and the
// result sink.
//   in_*      : element-pair stream (valid/ready, in_last marks final element)
//   mac_a/b   : packed lane operands to the MAC, lane k at [bw*(k+1)-1 : bw*k]
//   mac_out   : MAC sum, combinational from MAC product registers
//   out_*     : dot-product result (valid/ready)
// slave  = the feeder, master = the surrounding environment.
interface mac_16in_feeder_if;
  import mac_pkg::*;

  logic                      in_valid;
  logic                      in_ready;
  logic signed [bw-1:0]      in_a;
  logic signed [bw-1:0]      in_b;
  logic                      in_last;
  logic [pr*bw-1:0]          mac_a;
  logic [pr*bw-1:0]          mac_b;
  logic signed [bw_psum-1:0] mac_out;
  logic                      out_valid;
  logic                      out_ready;
  logic signed [acc_bw-1:0]  out_data;

  modport slave (
    input  in_valid, in_a, in_b, in_last, mac_out, out_ready,
    output in_ready, mac_a, mac_b, out_valid, out_data
  );

  modport master (
    output in_valid, in_a, in_b, in_last, mac_out, out_ready,
    input  in_ready, mac_a, mac_b, out_valid, out_data
  );

endinterface

// File: rtl/mac_16in_feeder.sv
// Packs a serial (a, b) element stream into 16-lane MAC operand vectors,
// accumulates the sign-extended MAC sum per group and hands the final
// dot-product out over valid/ready.
// Ports:
//   clk      : rising-edge clock
//   reset_n  : asynchronous active-low reset
//   bus      : mac_16in_feeder_if.slave (element input, MAC lanes, result)
module mac_16in_feeder
  import mac_pkg::*;
(
  input  logic               clk,
  input  logic               reset_n,
  mac_16in_feeder_if.slave   bus
);

  state_t                    state;
  logic [cnt_w-1:0]          cnt;
  logic signed [acc_bw-1:0]  acc;
  logic                      last_grp;
  logic                      in_ready_q;
  logic                      out_valid_q;
  logic [pr-1:0][bw-1:0]     lane_a;
  logic [pr-1:0][bw-1:0]     lane_b;

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = acc;
  assign bus.mac_a     = lane_a;
  assign bus.mac_b     = lane_b;

  // Group sequencer; lanes are cleared on every entry to FILL so a short
  // group leaves unused lanes at zero.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= FILL;
      cnt         <= '0;
      acc         <= '0;
      last_grp    <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      lane_a      <= '0;
      lane_b      <= '0;
    end else begin
      case (state)
        FILL: begin
          if (bus.in_valid && in_ready_q) begin
            lane_a[cnt] <= bus.in_a;
            lane_b[cnt] <= bus.in_b;
            if ((cnt == cnt_w'(pr - 1)) || bus.in_last) begin
              state      <= WAIT;
              last_grp   <= bus.in_last;
              in_ready_q <= 1'b0;
            end else begin
              cnt <= cnt + cnt_w'(1);
            end
          end
        end
        // MAC captures products on this edge.
        WAIT: state <= ACCUM;
        ACCUM: begin
          acc <= acc + sext(bus.mac_out);
          if (last_grp) begin
            state       <= DONE;
            out_valid_q <= 1'b1;
          end else begin
            state      <= FILL;
            cnt        <= '0;
            lane_a     <= '0;
            lane_b     <= '0;
            in_ready_q <= 1'b1;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state       <= FILL;
            acc         <= '0;
            cnt         <= '0;
            lane_a      <= '0;
            lane_b      <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: state <= FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_mac_16in_feeder.sv
// Directed bench for mac_16in_feeder with a behavioural 16-lane MAC
// (one-cycle product registers without reset, combinational sum).
module tb_mac_16in_feeder;
  import mac_pkg::*;

  logic clk;
  logic reset_n;
  int   n_checks;
  int   n_pass;
  int   cyc;
  int   last_cyc;

  mac_16in_feeder_if bus ();

  mac_16in_feeder dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural MAC: products registered each cycle, sum combinational.
  logic signed [2*bw-1:0]  prod [pr];
  logic signed [bw_psum-1:0] mac_sum;

  always @(posedge clk) begin
    for (int k = 0; k < pr; k++)
      prod[k] <= $signed(bus.mac_a[k*bw +: bw]) * $signed(bus.mac_b[k*bw +: bw]);
  end

  always_comb begin
    mac_sum = '0;
    for (int k = 0; k < pr; k++)
      mac_sum = mac_sum + bw_psum'(prod[k]);
  end

  assign bus.mac_out = mac_sum;

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Offer one element after `gap` idle cycles; returns #1 after the accepting edge.
  task automatic send(input int a, input int b, input logic last, input int gap);
    int t;
    t = 0;
    bus.in_valid = 1'b0;
    repeat (gap) @(negedge clk);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_a     = bw'(a);
    bus.in_b     = bw'(b);
    bus.in_last  = last;
    while (!bus.in_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) check("send_timeout", 1, 0);
    @(posedge clk);
    #1;
    if (last) last_cyc = cyc;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic send_group(input int a, input int b, input int n, input logic last_grp);
    for (int k = 0; k < n; k++)
      send(a, b, last_grp && (k == n - 1), 0);
  endtask

  // Wait for the result, hold out_ready low for `hold` cycles, then hand off.
  task automatic get_result(input string tag, input longint exp, input int hold);
    int t;
    t = 0;
    do begin
      @(posedge clk);
      #1;
      t++;
      if (!bus.out_valid) check({tag, "_in_ready_busy"}, longint'(bus.in_ready), 0);
    end while (!bus.out_valid && t < 50);
    if (!bus.out_valid) begin
      check({tag, "_result_timeout"}, 1, 0);
      return;
    end
    check({tag, "_latency"}, longint'(cyc - last_cyc), 2);
    check({tag, "_data"}, longint'(bus.out_data), exp);
    for (int h = 0; h < hold; h++) begin
      @(posedge clk);
      #1;
      check({tag, "_hold_valid"}, longint'(bus.out_valid), 1);
      check({tag, "_hold_data"}, longint'(bus.out_data), exp);
      check({tag, "_hold_in_ready"}, longint'(bus.in_ready), 0);
    end
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    check({tag, "_drop_valid"}, longint'(bus.out_valid), 0);
    check({tag, "_rise_in_ready"}, longint'(bus.in_ready), 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"}, longint'(bus.in_ready), 1);
    check({tag, "_out_valid"}, longint'(bus.out_valid), 0);
    check({tag, "_out_data"}, longint'(bus.out_data), 0);
    check({tag, "_mac_a_zero"}, longint'(bus.mac_a != '0), 0);
    check({tag, "_mac_b_zero"}, longint'(bus.mac_b != '0), 0);
  endtask

  initial begin
    n_checks      = 0;
    n_pass        = 0;
    cyc           = 0;
    last_cyc      = 0;
    reset_n       = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;

    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    reset_n = 1'b1;
    @(negedge clk);
    check_reset_outputs("post_rst");

    // Single group: sum of 1..16.
    for (int k = 0; k < pr; k++) send(k + 1, 1, k == pr - 1, 0);
    get_result("single", 136, 0);

    // Signed extremes across two groups, then one mixed-sign group.
    send_group(-128, -128, pr, 1'b0);
    send_group(-128, -128, pr, 1'b1);
    get_result("neg_neg", 524288, 0);
    send_group(-128, 127, pr, 1'b1);
    get_result("neg_pos", -260096, 0);

    // Short group after a full one; unused lanes must stay zero.
    send_group(5, 5, pr, 1'b0);
    send_group(2, 3, 5, 1'b1);
    check("short_a_low", longint'(bus.mac_a[39:0]), 40'h02_02_02_02_02);
    check("short_b_low", longint'(bus.mac_b[39:0]), 40'h03_03_03_03_03);
    check("short_a_hi_zero", longint'(bus.mac_a[pr*bw-1:40] != '0), 0);
    check("short_b_hi_zero", longint'(bus.mac_b[pr*bw-1:40] != '0), 0);
    // Backpressure on this result.
    get_result("short", 430, 10);
    send_group(1, 1, pr, 1'b1);
    get_result("after_bp", 16, 0);

    // Reset mid-fill with a non-zero partial accumulator.
    send_group(5, 5, pr, 1'b0);
    send_group(9, 9, 7, 1'b0);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check_reset_outputs("mid_rst");
    @(negedge clk);
    reset_n = 1'b1;
    send_group(1, 2, pr, 1'b1);
    get_result("after_rst", 32, 0);

    // Four groups with idle gaps on in_valid.
    for (int g = 0; g < 4; g++)
      for (int k = 0; k < pr; k++)
        send(3, -1, (g == 3) && (k == pr - 1), int'($urandom_range(3, 0)));
    get_result("bubbles", -192, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
